// File: rtl/sys_defs.sv
// Shared core definitions: data widths, the ROB entry layout and the retire packet.
package sys_defs;

  localparam int XLEN   = 32;
  localparam int ROB_SZ = 8;

  localparam logic [4:0] ZERO_REG = 5'd0;

  // Register write performed by the retire stage.
  typedef struct packed {
    logic [4:0]      r;
    logic [XLEN-1:0] V;
  } RT_DATA;

  // Registered packet handed to the retire stage.
  typedef struct packed {
    logic            valid;
    logic            take_branch;
    logic [XLEN-1:0] NPC;
    RT_DATA          data_retired;
  } ROB_RT_PACKET;

  // One reorder-buffer slot.
  typedef struct packed {
    logic            valid;
    logic            complete;
    logic [4:0]      dest_reg;
    logic [XLEN-1:0] V;
    logic            take_branch;
    logic            mispredict;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] NPC;
  } ROB_ENTRY;

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order allocation at dispatch, out-of-order completion from
// the CDB, in-order single retire per cycle, full flush on a mispredicted retire.
module rob
  import sys_defs::*;
#(
  parameter int ROB_SZ = sys_defs::ROB_SZ,
  parameter int TAG_W  = $clog2(ROB_SZ)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dp_valid,
  input  logic [4:0]        dp_dest_reg,
  input  logic [XLEN-1:0]   dp_NPC,
  output logic [TAG_W-1:0]  dp_rob_tag,
  output logic              rob_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [XLEN-1:0]   cdb_value,
  input  logic              cdb_take_branch,
  input  logic              cdb_mispredict,
  input  logic [XLEN-1:0]   cdb_target,
  output ROB_RT_PACKET      rob_rt_packet,
  output logic              squash,
  output logic [XLEN-1:0]   squash_pc
);

  ROB_ENTRY         entries [ROB_SZ];
  ROB_ENTRY         head_entry;
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;

  logic dp_accept;
  logic cdb_accept;
  logic retire;
  logic flush;

  assign dp_rob_tag = tail;

  // Accept/retire decisions, all taken from registered state. rob_full uses the
  // registered count, so a same-cycle retire never frees a slot for dispatch.
  // While squash is high the upstream is being redirected, so dp/cdb are ignored.
  always_comb begin
    head_entry = entries[head];
    rob_full   = (count == (TAG_W+1)'(ROB_SZ));
    dp_accept  = dp_valid && !rob_full && !squash;
    cdb_accept = cdb_valid && !squash && entries[cdb_tag].valid;
    retire     = head_entry.valid && head_entry.complete;
    flush      = retire && head_entry.mispredict;
  end

  // Entry storage: completion capture, retire clear, dispatch allocate, flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ROB_SZ; i++) begin
        entries[i] <= '0;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < ROB_SZ; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (cdb_accept) begin
        entries[cdb_tag].complete    <= 1'b1;
        entries[cdb_tag].V           <= cdb_value;
        entries[cdb_tag].take_branch <= cdb_take_branch;
        entries[cdb_tag].mispredict  <= cdb_mispredict;
        entries[cdb_tag].target      <= cdb_target;
      end
      // head == tail with a valid head means full, which blocks dispatch,
      // so the retire clear and the allocation never hit the same slot.
      if (retire) begin
        entries[head] <= '0;
      end
      if (dp_accept) begin
        entries[tail] <= '{valid:       1'b1,
                           complete:    1'b0,
                           dest_reg:    dp_dest_reg,
                           V:           '0,
                           take_branch: 1'b0,
                           mispredict:  1'b0,
                           target:      '0,
                           NPC:         dp_NPC};
      end
    end
  end

  // Head/tail pointers and occupancy; wrap is implicit in the power-of-two width.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + TAG_W'(retire);
      tail  <= tail + TAG_W'(dp_accept);
      count <= count + (TAG_W+1)'(dp_accept) - (TAG_W+1)'(retire);
    end
  end

  // Registered retire packet and one-cycle squash pulse with redirect PC.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rob_rt_packet <= '0;
      squash        <= 1'b0;
      squash_pc     <= '0;
    end else begin
      rob_rt_packet <= '0;
      squash        <= flush;
      squash_pc     <= flush ? head_entry.target : '0;
      if (retire) begin
        rob_rt_packet.valid          <= 1'b1;
        rob_rt_packet.take_branch    <= head_entry.take_branch;
        rob_rt_packet.NPC            <= head_entry.NPC;
        rob_rt_packet.data_retired.r <= head_entry.dest_reg;
        rob_rt_packet.data_retired.V <= head_entry.V;
      end
    end
  end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a queue-based model.
module tb_rob;
  import sys_defs::*;

  localparam int SZ = 8;

  logic              clock;
  logic              reset;
  logic              dp_valid;
  logic [4:0]        dp_dest_reg;
  logic [XLEN-1:0]   dp_NPC;
  logic [2:0]        dp_rob_tag;
  logic              rob_full;
  logic              cdb_valid;
  logic [2:0]        cdb_tag;
  logic [XLEN-1:0]   cdb_value;
  logic              cdb_take_branch;
  logic              cdb_mispredict;
  logic [XLEN-1:0]   cdb_target;
  ROB_RT_PACKET      rob_rt_packet;
  logic              squash;
  logic [XLEN-1:0]   squash_pc;

  rob #(.ROB_SZ(SZ)) dut (
    .clock(clock), .reset(reset),
    .dp_valid(dp_valid), .dp_dest_reg(dp_dest_reg), .dp_NPC(dp_NPC),
    .dp_rob_tag(dp_rob_tag), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_take_branch(cdb_take_branch), .cdb_mispredict(cdb_mispredict),
    .cdb_target(cdb_target),
    .rob_rt_packet(rob_rt_packet), .squash(squash), .squash_pc(squash_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: program-order queue of in-flight instructions.
  typedef struct {
    int          tag;
    logic [4:0]  dest;
    logic [31:0] npc;
    bit          done;
    logic [31:0] v;
    bit          tb;
    bit          mp;
    logic [31:0] tgt;
  } m_ent_t;

  m_ent_t       q[$];
  int           m_tail;
  bit           m_squash;
  logic [31:0]  m_spc;
  ROB_RT_PACKET e_pkt;
  logic [2:0]   pre_tag;

  task automatic model_clear();
    q.delete();
    m_tail   = 0;
    m_squash = 0;
    m_spc    = 0;
    e_pkt    = '0;
  endtask

  task automatic model_edge(input bit dv, input logic [4:0] dr, input logic [31:0] dn,
                            input bit cv, input logic [2:0] ct, input logic [31:0] cval,
                            input bit ctb, input bit cmp, input logic [31:0] ctgt);
    bit full, ret, fl;
    m_ent_t e;
    full  = (q.size() == SZ);
    ret   = (q.size() > 0) && q[0].done;
    fl    = ret && q[0].mp;
    e_pkt = '0;
    if (ret) begin
      e_pkt.valid          = 1'b1;
      e_pkt.take_branch    = q[0].tb;
      e_pkt.NPC            = q[0].npc;
      e_pkt.data_retired.r = q[0].dest;
      e_pkt.data_retired.V = q[0].v;
      void'(q.pop_front());
    end
    if (fl) begin
      m_spc = q.size() >= 0 ? 32'(0) : 32'(0);
    end
    if (fl) begin
      q.delete();
      m_tail = 0;
    end else begin
      if (cv && !m_squash) begin
        foreach (q[i]) begin
          if (q[i].tag == int'(ct)) begin
            q[i].done = 1; q[i].v = cval; q[i].tb = ctb; q[i].mp = cmp; q[i].tgt = ctgt;
          end
        end
      end
      if (dv && !full && !m_squash) begin
        e = '{tag: m_tail, dest: dr, npc: dn, done: 0, v: 0, tb: 0, mp: 0, tgt: 0};
        q.push_back(e);
        m_tail = (m_tail + 1) % SZ;
      end
    end
    m_squash = fl;
  endtask

  // One cycle: drive at negedge, check combinational outputs, clock, check registered outputs.
  task automatic step(input bit dv, input logic [4:0] dr, input logic [31:0] dn,
                      input bit cv, input logic [2:0] ct, input logic [31:0] cval,
                      input bit ctb, input bit cmp, input logic [31:0] ctgt);
    logic [31:0] spc_next;
    dp_valid = dv; dp_dest_reg = dr; dp_NPC = dn;
    cdb_valid = cv; cdb_tag = ct; cdb_value = cval;
    cdb_take_branch = ctb; cdb_mispredict = cmp; cdb_target = ctgt;
    #1;
    pre_tag = dp_rob_tag;
    chk("dp_rob_tag", dp_rob_tag, 128'(m_tail));
    chk("rob_full", rob_full, 128'(q.size() == SZ));
    spc_next = (q.size() > 0 && q[0].done && q[0].mp) ? q[0].tgt : 32'h0;
    @(posedge clock);
    model_edge(dv, dr, dn, cv, ct, cval, ctb, cmp, ctgt);
    m_spc = spc_next;
    #1;
    chk("rt_packet", rob_rt_packet, e_pkt);
    chk("squash", squash, 128'(m_squash));
    if (m_squash) chk("squash_pc", squash_pc, m_spc);
    @(negedge clock);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic dispatch(input logic [4:0] dr, input logic [31:0] dn);
    step(1, dr, dn, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic complete(input logic [2:0] t, input logic [31:0] v);
    step(0, 0, 0, 1, t, v, 0, 0, 0);
  endtask

  // Asynchronous reset asserted away from any clock edge.
  task automatic do_reset();
    dp_valid = 0; cdb_valid = 0;
    #2 reset = 1'b0;
    #1;
    chk("rst_packet", rob_rt_packet, 128'(0));
    chk("rst_squash", squash, 128'(0));
    chk("rst_full", rob_full, 128'(0));
    chk("rst_tag", dp_rob_tag, 128'(0));
    model_clear();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  typedef struct {
    bit dv; logic [4:0] dr; logic [31:0] dn;
    bit cv; logic [2:0] ct; logic [31:0] cval; bit ctb; bit cmp; logic [31:0] ctgt;
    logic [2:0] e_tag; bit e_pv; logic [4:0] e_r; logic [31:0] e_v; bit e_sq; logic [31:0] e_spc;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(bit dv, logic [4:0] dr, logic [31:0] dn,
                              bit cv, logic [2:0] ct, logic [31:0] cval, bit ctb, bit cmp,
                              logic [31:0] ctgt, logic [2:0] e_tag, bit e_pv, logic [4:0] e_r,
                              logic [31:0] e_v, bit e_sq, logic [31:0] e_spc);
    vec_t v;
    v = '{dv, dr, dn, cv, ct, cval, ctb, cmp, ctgt, e_tag, e_pv, e_r, e_v, e_sq, e_spc};
    return v;
  endfunction

  initial begin
    bit          dv, cv, mp, stale_ok;
    logic [2:0]  ct;
    int          cand[$];

    reset = 1'b0;
    dp_valid = 0; dp_dest_reg = 0; dp_NPC = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
    cdb_take_branch = 0; cdb_mispredict = 0; cdb_target = 0;
    model_clear();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // In-order retire, stale CDB, and mispredict flush.
    tbl[0]  = mk(1, 5, 32'h1004, 0, 0, 0,        0, 0, 0,        0, 0, 0, 0,         0, 0);
    tbl[1]  = mk(1, 6, 32'h1008, 0, 0, 0,        0, 0, 0,        1, 0, 0, 0,         0, 0);
    tbl[2]  = mk(0, 0, 0,        1, 1, 32'h22,   0, 0, 0,        2, 0, 0, 0,         0, 0);
    tbl[3]  = mk(0, 0, 0,        1, 0, 32'h11,   0, 0, 0,        2, 0, 0, 0,         0, 0);
    tbl[4]  = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,        2, 1, 5, 32'h11,    0, 0);
    tbl[5]  = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,        2, 1, 6, 32'h22,    0, 0);
    tbl[6]  = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,        2, 0, 0, 0,         0, 0);
    tbl[7]  = mk(0, 0, 0,        1, 3, 32'h33,   0, 0, 0,        2, 0, 0, 0,         0, 0);
    tbl[8]  = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,        2, 0, 0, 0,         0, 0);
    tbl[9]  = mk(1, 7, 32'h2000, 0, 0, 0,        0, 0, 0,        2, 0, 0, 0,         0, 0);
    tbl[10] = mk(1, 8, 32'h2004, 0, 0, 0,        0, 0, 0,        3, 0, 0, 0,         0, 0);
    tbl[11] = mk(0, 0, 0,        1, 2, 32'h77,   0, 0, 0,        4, 0, 0, 0,         0, 0);
    tbl[12] = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,        4, 1, 7, 32'h77,    0, 0);
    tbl[13] = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,        4, 0, 0, 0,         0, 0);
    tbl[14] = mk(0, 0, 0,        1, 3, 32'h44,   0, 0, 0,        4, 0, 0, 0,         0, 0);
    tbl[15] = mk(0, 0, 0,        0, 0, 0,        0, 0, 0,        4, 1, 8, 32'h44,    0, 0);
    tbl[16] = mk(1, 1, 32'h104,  0, 0, 0,        0, 0, 0,        4, 0, 0, 0,         0, 0);
    tbl[17] = mk(1, 9, 32'h108,  0, 0, 0,        0, 0, 0,        5, 0, 0, 0,         0, 0);
    tbl[18] = mk(1, 10, 32'h10c, 0, 0, 0,        0, 0, 0,        6, 0, 0, 0,         0, 0);
    tbl[19] = mk(0, 0, 0,        1, 4, 32'h104,  1, 1, 32'h200,  7, 0, 0, 0,         0, 0);
    tbl[20] = mk(1, 13, 32'h110, 0, 0, 0,        0, 0, 0,        7, 1, 1, 32'h104,   1, 32'h200);
    tbl[21] = mk(1, 12, 32'h300, 0, 0, 0,        0, 0, 0,        0, 0, 0, 0,         0, 0);
    tbl[22] = mk(1, 11, 32'h400, 0, 0, 0,        0, 0, 0,        0, 0, 0, 0,         0, 0);

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].dv, tbl[i].dr, tbl[i].dn, tbl[i].cv, tbl[i].ct, tbl[i].cval,
           tbl[i].ctb, tbl[i].cmp, tbl[i].ctgt);
      chk($sformatf("tbl%0d_tag", i), pre_tag, tbl[i].e_tag);
      chk($sformatf("tbl%0d_pv", i), rob_rt_packet.valid, tbl[i].e_pv);
      if (tbl[i].e_pv) begin
        chk($sformatf("tbl%0d_r", i), rob_rt_packet.data_retired.r, tbl[i].e_r);
        chk($sformatf("tbl%0d_V", i), rob_rt_packet.data_retired.V, tbl[i].e_v);
      end
      chk($sformatf("tbl%0d_sq", i), squash, tbl[i].e_sq);
      if (tbl[i].e_sq) chk($sformatf("tbl%0d_spc", i), squash_pc, tbl[i].e_spc);
    end

    // Reset with three entries in flight.
    dispatch(14, 32'h500);
    dispatch(15, 32'h504);
    do_reset();
    idle();

    // Fill to capacity, 9th dispatch ignored, retire tag 0, reallocate wrapped tag 0.
    for (int i = 0; i < SZ; i++) dispatch(5'(16 + i), 32'h3000 + 32'(4 * i));
    chk("full8", rob_full, 128'(1));
    dispatch(31, 32'hdead);
    complete(0, 32'haa);
    idle();
    chk("wrap_pkt_r", rob_rt_packet.data_retired.r, 128'(16));
    chk("wrap_tag", dp_rob_tag, 128'(0));
    dispatch(30, 32'h4000);
    chk("wrap_full", rob_full, 128'(1));

    // Simultaneous dispatch and retire at count 4.
    do_reset();
    for (int i = 0; i < 4; i++) dispatch(5'(2 + i), 32'h5000 + 32'(4 * i));
    complete(0, 32'h55);
    dispatch(20, 32'h6000);
    chk("sim_pkt", rob_rt_packet.valid, 128'(1));
    chk("sim_tag", dp_rob_tag, 128'(5));
    for (int i = 0; i < 3; i++) dispatch(5'(21 + i), 32'h6100);
    chk("sim_notfull", rob_full, 128'(0));
    dispatch(24, 32'h6200);
    chk("sim_full", rob_full, 128'(1));

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      dv = ($urandom_range(0, 9) < 6);
      cv = 0;
      ct = 0;
      cand.delete();
      foreach (q[i]) if (!q[i].done) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 9) < 5) begin
        cv = 1;
        ct = 3'(q[cand[$urandom_range(0, cand.size() - 1)]].tag);
      end else if ($urandom_range(0, 9) == 0) begin
        ct = 3'($urandom);
        stale_ok = 1;
        foreach (q[i]) if (q[i].tag == int'(ct)) stale_ok = 0;
        cv = stale_ok;
      end
      mp = ($urandom_range(0, 24) == 0);
      step(dv, 5'($urandom), $urandom, cv, ct, $urandom, 1'($urandom_range(0, 1)), mp, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
